// File: rtl/custom_fifo.sv
// custom_fifo: synchronous AXI-Stream FIFO between an accelerator output stream and a DMA input
// stream. Buffers up to Depth beats with first-word fall-through on the master side and
// generates TLAST on every PacketLen-th beat delivered, since the upstream stream has no
// packet delimiter. Data passes through unmodified and in order.
//
// Ports:
//   clk_i            single clock, all state updates on the rising edge
//   rst_i            synchronous reset, active-high
//   s_axis_tvalid_i  upstream beat valid
//   s_axis_tdata_i   upstream beat data
//   s_axis_tready_o  FIFO can accept a beat (not full, not in reset)
//   m_axis_tvalid_o  FIFO holds at least one beat (not in reset)
//   m_axis_tdata_o   oldest stored beat
//   m_axis_tlast_o   current output beat ends a packet
//   m_axis_tready_i  downstream accepts the beat
module custom_fifo #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned Depth     = 8,  // power of two, >= 2
  parameter int unsigned PacketLen = 8   // >= 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 s_axis_tvalid_i,
  input  logic [DataWidth-1:0] s_axis_tdata_i,
  output logic                 s_axis_tready_o,
  output logic                 m_axis_tvalid_o,
  output logic [DataWidth-1:0] m_axis_tdata_o,
  output logic                 m_axis_tlast_o,
  input  logic                 m_axis_tready_i
);

  localparam int unsigned PtrW  = $clog2(Depth);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BeatW = (PacketLen > 1) ? $clog2(PacketLen) : 1;

  localparam logic [CntW-1:0]  CountFull = CntW'(Depth);
  localparam logic [BeatW-1:0] BeatLast  = BeatW'(PacketLen - 1);

  logic [DataWidth-1:0] mem_q [Depth];

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [BeatW-1:0] beat_q, beat_d;

  logic empty, full;
  logic wr_en, rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == CountFull);

  // Handshake outputs depend only on state and reset, never on the opposite side's inputs, so
  // a full FIFO cannot pass a beat through and an empty one never bypasses to the output.
  assign s_axis_tready_o = !full && !rst_i;
  assign m_axis_tvalid_o = !empty && !rst_i;
  assign m_axis_tdata_o  = mem_q[rd_ptr_q];
  assign m_axis_tlast_o  = m_axis_tvalid_o && (beat_q == BeatLast);

  assign wr_en = s_axis_tvalid_i && s_axis_tready_o;
  assign rd_en = m_axis_tvalid_o && m_axis_tready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    beat_d   = beat_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
      beat_d   = (beat_q == BeatLast) ? '0 : beat_q + BeatW'(1);
    end

    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      beat_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      beat_q   <= beat_d;
    end
  end

  // Storage is deliberately not reset; wr_en is already blocked during reset via tready.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= s_axis_tdata_i;
    end
  end

endmodule

// File: tb/tb_custom_fifo.sv
module tb_custom_fifo;

  logic       clk;
  logic       rst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_ready;

  int checks;
  int errors;

  // Expected output beats: {data, tlast}.
  logic [8:0] exp_q[$];
  int         wr_idx;

  custom_fifo #(
    .DataWidth(8),
    .Depth    (8),
    .PacketLen(8)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .s_axis_tvalid_i(s_valid),
    .s_axis_tdata_i (s_data),
    .s_axis_tready_o(s_ready),
    .m_axis_tvalid_o(m_valid),
    .m_axis_tdata_o (m_data),
    .m_axis_tlast_o (m_last),
    .m_axis_tready_i(m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard push: each accepted input beat becomes an expected output beat. Packet position
  // is counted from reset, so beat index 7, 15, ... carries tlast.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      wr_idx = 0;
    end else if (s_valid && s_ready) begin
      exp_q.push_back({s_data, logic'((wr_idx % 8) == 7)});
      wr_idx++;
    end
  end

  // Scoreboard pop/compare on every output transfer.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual=%0h required=none at %0t", m_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("m_data", 32'(m_data), 32'(e[8:1]));
        chk("m_last", 32'(m_last), 32'(e[0]));
      end
    end
  end

  // A presented, unaccepted beat must stay valid and unchanged until accepted.
  logic       stall_q;
  logic [7:0] stall_data;
  logic       stall_last;
  initial stall_q = 1'b0;
  always @(negedge clk) begin
    if (!rst && stall_q) begin
      chk("stall_valid", 32'(m_valid), 32'd1);
      chk("stall_data", 32'(m_data), 32'(stall_data));
      chk("stall_last", 32'(m_last), 32'(stall_last));
    end
    stall_q    = !rst && m_valid && !m_ready;
    stall_data = m_data;
    stall_last = m_last;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_valid) break;
      next_cycle();
    end
    chk({name, "_left"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_valid"}, 32'(m_valid), 32'd0);
  endtask

  task automatic stream(input logic [7:0] base, input int n, input string name);
    int k;
    k       = 0;
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 200 && k < n; c++) begin
      s_data = base + 8'(k);
      @(negedge clk);
      chk({name, "_s_ready"}, 32'(s_ready), 32'd1);
      if (c > 0) chk({name, "_m_valid"}, 32'(m_valid), 32'd1);
      if (s_ready) k++;
      next_cycle();
    end
    chk({name, "_sent"}, 32'(k), 32'(n));
    s_valid = 1'b0;
  endtask

  initial begin
    int accepted;
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h11;
    m_ready = 1'b0;

    // Reset held two cycles with upstream valid: nothing may be accepted.
    repeat (2) begin
      @(negedge clk);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_last", 32'(m_last), 32'd0);
      next_cycle();
    end
    rst     = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_m_valid", 32'(m_valid), 32'd0);
    chk("post_rst_s_ready", 32'(s_ready), 32'd1);
    next_cycle();

    // Fill with AA, 55, FF... while downstream stalls: exactly 8 beats fit.
    accepted = 0;
    m_ready  = 1'b0;
    s_valid  = 1'b1;
    for (int i = 0; i < 11; i++) begin
      s_data = (accepted == 0) ? 8'hAA : (accepted == 1) ? 8'h55 : 8'hFF;
      @(negedge clk);
      chk("fill_s_ready", 32'(s_ready), (i < 8) ? 32'd1 : 32'd0);
      chk("fill_m_valid", 32'(m_valid), (i >= 1) ? 32'd1 : 32'd0);
      if (s_ready) accepted++;
      next_cycle();
    end
    chk("fill_accepted", 32'(accepted), 32'd8);

    // Drain: tready returns one cycle after the first read; valid drops after beat 8.
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("drain_m_valid", 32'(m_valid), (i < 8) ? 32'd1 : 32'd0);
      chk("drain_s_ready", 32'(s_ready), (i >= 1) ? 32'd1 : 32'd0);
      next_cycle();
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);

    // Empty with downstream ready: nothing appears.
    repeat (4) begin
      @(negedge clk);
      chk("empty_m_valid", 32'(m_valid), 32'd0);
      chk("empty_m_last", 32'(m_last), 32'd0);
      next_cycle();
    end

    // Streaming 0x00..0x13; packet count continues, so tlast lands on 0x07 and 0x0F.
    stream(8'h00, 20, "stream");
    drain("stream_drain");

    // Backpressure mid-packet, then reset.
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data = 8'hA0 + 8'(i);
      @(negedge clk);
      chk("bp_s_ready", 32'(s_ready), 32'd1);
      next_cycle();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (3) next_cycle();
    m_ready = 1'b0;
    repeat (2) next_cycle();
    for (int i = 0; i < 6; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      next_cycle();
    end
    rst     = 1'b1;
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h5A;
    @(negedge clk);
    chk("mid_rst_s_ready", 32'(s_ready), 32'd0);
    chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_m_last", 32'(m_last), 32'd0);
    next_cycle();
    rst     = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    chk("after_rst_m_valid", 32'(m_valid), 32'd0);
    next_cycle();

    // Packet count restarts: tlast on 0xB7, the 8th beat after reset.
    stream(8'hB0, 10, "post_rst");
    drain("post_rst_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
